// File: rtl/spatz_tcdm_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spatz_tcdm_bank_arbiter
// Description : Round-robin arbiter sharing one single-port TCDM SRAM bank
//               (1-cycle read latency) between NUM_REQ requesters. At most
//               one request is granted per cycle and driven straight to the
//               bank; the winner gets its response strobe one cycle later.
//               A saturating counter records cycles with two or more
//               simultaneous requests.
// Ports       : clk_i, rst_ni        clock, asynchronous active-low reset
//               req_*_i / req_ready_o per-requester request channel
//               rsp_valid_o           per-requester response strobe
//               rsp_rdata_o           shared read data
//               bank_*                SRAM macro interface
//               conflict_cnt_o        saturating conflict-cycle counter
// Revision    : 1.0 - initial release
// ============================================================================
module spatz_tcdm_bank_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int BE_WIDTH   = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ-1:0]             req_write_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata_i,
    input  logic [NUM_REQ*BE_WIDTH-1:0]    req_be_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
    output logic                           bank_req_o,
    output logic                           bank_we_o,
    output logic [ADDR_WIDTH-1:0]          bank_addr_o,
    output logic [DATA_WIDTH-1:0]          bank_wdata_o,
    output logic [BE_WIDTH-1:0]            bank_be_o,
    input  logic [DATA_WIDTH-1:0]          bank_rdata_i,
    output logic [CNT_WIDTH-1:0]           conflict_cnt_o
);

    localparam int                    c_rr_width = $clog2(NUM_REQ);
    localparam logic [c_rr_width-1:0] c_last_idx = c_rr_width'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_rr_width-1:0] r_rr;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic                  r_rsp_write;
    logic [CNT_WIDTH-1:0]  r_conflict;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]    w_upper_mask;
    logic [NUM_REQ-1:0]    w_req_upper;
    logic [NUM_REQ-1:0]    w_pick;
    logic [NUM_REQ-1:0]    w_gnt_oh;
    logic [c_rr_width-1:0] w_gnt_idx;
    logic                  w_gnt_valid;
    logic [c_rr_width-1:0] w_rr_next;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BE_WIDTH-1:0]   w_be;
    logic                  w_multi;
    logic                  w_bank_en;

    // Round-robin scan starting at r_rr: prefer the lowest valid index at or
    // above the pointer; if there is none, wrap and take the lowest valid
    // index overall. This is equivalent to scanning r_rr, r_rr+1, ... modulo
    // NUM_REQ and works for non-power-of-two requester counts.
    always_comb begin
        w_upper_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_upper_mask[i] = (c_rr_width'(i) >= r_rr);
        end
        w_req_upper = req_valid_i & w_upper_mask;
        w_pick      = (|w_req_upper) ? w_req_upper : req_valid_i;

        w_gnt_oh  = '0;
        w_gnt_idx = '0;
        // Descending loop: the lowest set bit is written last and wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                w_gnt_oh    = '0;
                w_gnt_oh[i] = 1'b1;
                w_gnt_idx   = c_rr_width'(i);
            end
        end
        w_gnt_valid = |req_valid_i;
    end

    // Pointer moves one past the winner, wrapping at NUM_REQ.
    always_comb begin
        if (w_gnt_idx == c_last_idx) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_gnt_idx + c_rr_width'(1);
        end
    end

    // Winner field mux (AND-OR over the one-hot grant; all zero if no grant).
    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_we    = req_write_i[i];
                w_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_be    = req_be_i[i*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    // x & (x-1) clears the lowest set bit, so it is non-zero exactly when
    // two or more requesters are valid.
    assign w_multi = |(req_valid_i & (req_valid_i - NUM_REQ'(1)));

    // Combinational outputs are forced low while reset is held so that
    // every output reads 0 during reset, not only the registered ones.
    assign w_bank_en = rst_ni & w_gnt_valid;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready_o  = w_gnt_oh & {NUM_REQ{rst_ni}};
    assign bank_req_o   = w_bank_en;
    assign bank_we_o    = w_bank_en & w_we;
    assign bank_addr_o  = w_bank_en ? w_addr  : '0;
    assign bank_wdata_o = w_bank_en ? w_wdata : '0;
    // Reads always fetch the full word.
    assign bank_be_o    = !w_bank_en ? '0 : (w_we ? w_be : '1);

    assign rsp_valid_o  = r_rsp_valid;
    // Read data is only passed through for a pending read response.
    assign rsp_rdata_o  = ((|r_rsp_valid) && !r_rsp_write) ? bank_rdata_i : '0;

    assign conflict_cnt_o = r_conflict;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr        <= '0;
            r_rsp_valid <= '0;
            r_rsp_write <= 1'b0;
        end else begin
            if (w_gnt_valid) begin
                r_rr <= w_rr_next;
            end
            r_rsp_valid <= w_gnt_oh;
            r_rsp_write <= w_gnt_valid & w_we;
        end
    end

    // Saturating conflict counter: never wraps back to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_conflict <= '0;
        end else if (w_multi && (r_conflict != {CNT_WIDTH{1'b1}})) begin
            r_conflict <= r_conflict + CNT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire
